// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
//
// Drives the packed BCD word of the 6-digit hex display. Two requesters (the
// current score and the high score) share one sequential binary-to-BCD
// converter. The converter uses double dabble and handles one bit per clock.
// Each converted result is written into that requester's half of `num`.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   score_req  : current-score update request, held until score_ack
//   score_bin  : current score, unsigned binary [BIN_W-1:0]
//   score_ack  : one-cycle pulse, score operand captured
//   hi_req     : high-score update request, held until hi_ack
//   hi_bin     : high score, unsigned binary [BIN_W-1:0]
//   hi_ack     : one-cycle pulse, high-score operand captured
//   num        : packed BCD; upper half = high score, lower half = current
//                score; most significant digit first within each half
//   busy       : a conversion is in progress
// -----------------------------------------------------------------------------
module score_display_ctrl #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  score_req,
  input  logic [BIN_W-1:0]      score_bin,
  output logic                  score_ack,
  input  logic                  hi_req,
  input  logic [BIN_W-1:0]      hi_bin,
  output logic                  hi_ack,
  output logic [8*DIGITS-1:0]   num,
  output logic                  busy
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int MAX_DEC = 10**DIGITS - 1;
  // Comparison width wide enough for both the operand and the decimal limit.
  // When BIN_W cannot reach MAX_DEC, the clamp test is never true.
  localparam int CMP_W   = (BIN_W > 32) ? BIN_W : 32;

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [BIN_W-1:0]    bin_q,       bin_d;
  logic [BCD_W-1:0]    bcd_q,       bcd_d;
  logic                grant_hi_q,  grant_hi_d;   // field being converted
  logic                prefer_hi_q, prefer_hi_d;  // round-robin tie winner
  logic                score_ack_q, score_ack_d;
  logic                hi_ack_q,    hi_ack_d;
  logic                busy_q,      busy_d;
  logic [2*BCD_W-1:0]  num_q,       num_d;

  // Saturate operands the display cannot show (e.g. 1000..1023 -> 999).
  function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
    logic [CMP_W-1:0] wide;
    wide = CMP_W'(v);
    if (wide > CMP_W'(MAX_DEC)) return BIN_W'(MAX_DEC);
    return v;
  endfunction

  logic [BCD_W-1:0] adj;
  logic             pick_hi;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    grant_hi_d  = grant_hi_q;
    prefer_hi_d = prefer_hi_q;
    score_ack_d = 1'b0;
    hi_ack_d    = 1'b0;
    busy_d      = busy_q;
    num_d       = num_q;
    adj         = bcd_q;
    pick_hi     = 1'b0;

    // Double dabble correction: each nibble >= 5 gets +3 before the shift.
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (score_req || hi_req) begin
          // A lone requester always wins. On a tie, the pointer decides.
          pick_hi     = hi_req && (!score_req || prefer_hi_q);
          grant_hi_d  = pick_hi;
          bin_d       = clamp(pick_hi ? hi_bin : score_bin);
          bcd_d       = '0;
          cnt_d       = CNT_W'(BIN_W);
          score_ack_d = !pick_hi;
          hi_ack_d    = pick_hi;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = WRITE;
      end

      WRITE: begin
        if (grant_hi_q) num_d[2*BCD_W-1:BCD_W] = bcd_q;
        else            num_d[BCD_W-1:0]       = bcd_q;
        prefer_hi_d = !grant_hi_q;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // The operand and datapath registers are reset too. This keeps a
  // conversion that is aborted by reset from leaving state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      grant_hi_q  <= 1'b0;
      prefer_hi_q <= 1'b0;
      score_ack_q <= 1'b0;
      hi_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      num_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from
      // pre-edge values whatever the order of these statements.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      grant_hi_q  <= grant_hi_d;
      prefer_hi_q <= prefer_hi_d;
      score_ack_q <= score_ack_d;
      hi_ack_q    <= hi_ack_d;
      busy_q      <= busy_d;
      num_q       <= num_d;
    end
  end

  assign score_ack = score_ack_q;
  assign hi_ack    = hi_ack_q;
  assign busy      = busy_q;
  assign num       = num_q;

endmodule
